// File: rtl/sterownik_ledow_param.sv
// sterownik_ledow_param: LED ring rotation indicator driven by a ramped rpm (soft start / brake).
// Optional tail LED (previously passed sector) is enabled by defining LED_OGON_EN.
module sterownik_ledow_param #(
    parameter int N_LED    = 8,
    parameter int RPM_W    = 7,
    parameter int TAKT_W   = 9,
    parameter int SKALA    = 60,
    parameter int RAMP_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RPM_W-1:0]  rpm,
    input  logic              sygnal_zmiany_rpm,
    input  logic              rozruch,
    input  logic              kierunek,
    input  logic [TAKT_W-1:0] taktowanie_na_stopien,
    output logic [N_LED:1]    LED,
    output logic [1:0]        stan,
    output logic [RPM_W-1:0]  rpm_akt
);
    localparam int DEG_N   = 360 / N_LED;
    localparam int SEC_W   = N_LED > 1 ? $clog2(N_LED) : 1;
    localparam int DEG_W   = DEG_N > 1 ? $clog2(DEG_N) : 1;
    localparam int RD_W    = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
    localparam int ACC_MAX = SKALA + 2**RPM_W - 1;
    localparam int ACC_W   = $clog2(ACC_MAX + 2**RPM_W + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, ROZRUCH = 2'b01, PRACA = 2'b10, HAMOWANIE = 2'b11} stan_t;

    stan_t             stan_q, stan_d;
    logic [TAKT_W-1:0] cnt_q, cnt_d, t_lim;
    logic [RD_W-1:0]   ramp_q, ramp_d;
    logic [RPM_W-1:0]  rpm_akt_q, rpm_akt_d, rpm_cel_q, rpm_cel_d, goal;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum, acc_sub;
    logic [DEG_W-1:0]  deg_q, deg_d;
    logic [SEC_W-1:0]  sec_q, sec_d, sec_inc, sec_dec;
    logic [N_LED:1]    led_q, led_d;
    logic              tick, ramp_tick, deg_step, deg_wrap;

    // Next state: IDLE -> ROZRUCH -> PRACA, any running state brakes via HAMOWANIE back to IDLE
    always_comb begin
        stan_d = stan_q;
        case (stan_q)
            IDLE:      if (rozruch) stan_d = ROZRUCH;
            ROZRUCH:   if (!rozruch) stan_d = HAMOWANIE; else if (rpm_akt_q == rpm_cel_q) stan_d = PRACA;
            PRACA:     if (!rozruch) stan_d = HAMOWANIE;
            HAMOWANIE: if (rozruch) stan_d = ROZRUCH; else if (rpm_akt_q == '0) stan_d = IDLE;
            default:   stan_d = IDLE;
        endcase
    end

    // Prescaler, rpm ramp, angle accumulator, degree/sector counters and LED pattern
    always_comb begin
        t_lim     = (taktowanie_na_stopien == '0) ? TAKT_W'(1) : taktowanie_na_stopien;
        tick      = cnt_q >= t_lim - TAKT_W'(1);
        cnt_d     = tick ? '0 : cnt_q + TAKT_W'(1);
        ramp_tick = tick && (ramp_q == RD_W'(RAMP_DIV - 1));
        ramp_d    = ramp_tick ? '0 : (tick ? ramp_q + RD_W'(1) : ramp_q);
        goal      = (stan_q == ROZRUCH || stan_q == PRACA) ? rpm_cel_q : '0;
        rpm_akt_d = !ramp_tick ? rpm_akt_q :
                    (rpm_akt_q < goal) ? rpm_akt_q + RPM_W'(1) :
                    (rpm_akt_q > goal) ? rpm_akt_q - RPM_W'(1) : rpm_akt_q;
        rpm_cel_d = (sygnal_zmiany_rpm || (stan_q == IDLE && rozruch)) ? rpm : rpm_cel_q;
        // Speed is added once per tick, but one degree is drained per clock, so several
        // degrees per tick are possible; the clamp keeps acc bounded at extreme speeds.
        acc_sum   = acc_q + (tick ? ACC_W'(rpm_akt_q) : '0);
        deg_step  = acc_sum >= ACC_W'(SKALA);
        acc_sub   = deg_step ? acc_sum - ACC_W'(SKALA) : acc_sum;
        acc_d     = (acc_sub > ACC_W'(ACC_MAX)) ? ACC_W'(ACC_MAX) : acc_sub;
        deg_wrap  = deg_step && (deg_q == DEG_W'(DEG_N - 1));
        deg_d     = deg_wrap ? '0 : (deg_step ? deg_q + DEG_W'(1) : deg_q);
        sec_inc   = (sec_q == SEC_W'(N_LED - 1)) ? '0 : sec_q + SEC_W'(1);
        sec_dec   = (sec_q == '0) ? SEC_W'(N_LED - 1) : sec_q - SEC_W'(1);
        sec_d     = deg_wrap ? (kierunek ? sec_inc : sec_dec) : sec_q;
        if (stan_d == IDLE) begin
            acc_d = '0;
            deg_d = '0;
            sec_d = '0;
        end
`ifdef LED_OGON_EN
        led_d = (stan_q == IDLE) ? '0 :
                (N_LED'(1) << sec_q) | (N_LED'(1) << (kierunek ? sec_dec : sec_inc));
`else
        led_d = (stan_q == IDLE) ? '0 : N_LED'(1) << sec_q;
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stan_q    <= IDLE;
            cnt_q     <= '0;
            ramp_q    <= '0;
            rpm_akt_q <= '0;
            rpm_cel_q <= '0;
            acc_q     <= '0;
            deg_q     <= '0;
            sec_q     <= '0;
            led_q     <= '0;
        end else begin
            stan_q    <= stan_d;
            cnt_q     <= cnt_d;
            ramp_q    <= ramp_d;
            rpm_akt_q <= rpm_akt_d;
            rpm_cel_q <= rpm_cel_d;
            acc_q     <= acc_d;
            deg_q     <= deg_d;
            sec_q     <= sec_d;
            led_q     <= led_d;
        end
    end

    assign LED     = led_q;
    assign stan    = stan_q;
    assign rpm_akt = rpm_akt_q;
endmodule

// File: tb/tb_sterownik_ledow_param.sv
// tb_sterownik_ledow_param: directed checks of the LED ring indicator (N_LED=8, SKALA=4, RAMP_DIV=2, T=4).
`timescale 1ns/1ps
module tb_sterownik_ledow_param;
    localparam int N = 8;
`ifdef LED_OGON_EN
    localparam bit OGON = 1'b1;
`else
    localparam bit OGON = 1'b0;
`endif

    typedef struct {
        logic       roz;
        logic       kier;
        logic       syg;
        logic [6:0] rpm;
        int         budget;
        logic [1:0] e_stan;
        logic [6:0] e_akt;
        logic [8:1] e_led;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] rpm = '0;
    logic       syg = 1'b0, roz = 1'b0, kier = 1'b1;
    logic [8:0] takt = 9'd4;
    logic [8:1] led;
    logic [1:0] stan;
    logic [6:0] akt;
    int         checks = 0, failures = 0, cyc = 0;
    vec_t       v[10];

    sterownik_ledow_param #(.N_LED(8), .RPM_W(7), .TAKT_W(9), .SKALA(4), .RAMP_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .rpm(rpm), .sygnal_zmiany_rpm(syg), .rozruch(roz),
        .kierunek(kier), .taktowanie_na_stopien(takt), .LED(led), .stan(stan), .rpm_akt(akt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:1] led_of(input int s, input logic k);
        logic [8:1] r;
        r = '0;
        r[s + 1] = 1'b1;
        if (OGON) r[(k ? (s + N - 1) : (s + 1)) % N + 1] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_for(input logic [1:0] es, input logic [6:0] ea, input int budget, input string name);
        int n = 0;
        while (!(stan === es && akt === ea) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(stan === es && akt === ea)) begin
            failures++;
            $display("FAIL %s: stan=%0d rpm_akt=%0d, required stan=%0d rpm_akt=%0d within %0d clk",
                     name, stan, akt, es, ea, budget);
        end
    endtask

    task automatic wait_led(input logic [8:1] e, input int budget, input string name, output int t);
        int n = 0;
        while (led !== e && n < budget) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        chk(name, led, e);
    endtask

    initial begin
        int ts[4];
        int t1, t2;
        logic [6:0] a;
        v[0] = '{1'b0, 1'b1, 1'b0, 7'd5,  5, 2'b00, 7'd0, 8'h00};
        v[1] = '{1'b1, 1'b1, 1'b0, 7'd0,  5, 2'b10, 7'd0, led_of(0, 1'b1)};
        v[2] = '{1'b0, 1'b1, 1'b0, 7'd0,  5, 2'b00, 7'd0, 8'h00};
        v[3] = '{1'b1, 1'b1, 1'b0, 7'd5, 60, 2'b10, 7'd5, led_of(0, 1'b1)};
        v[4] = '{1'b1, 1'b1, 1'b1, 7'd2, 40, 2'b10, 7'd2, led_of(0, 1'b1)};
        v[5] = '{1'b1, 1'b1, 1'b1, 7'd7, 60, 2'b10, 7'd7, led_of(0, 1'b1)};
        v[6] = '{1'b0, 1'b1, 1'b0, 7'd7, 80, 2'b00, 7'd0, 8'h00};
        v[7] = '{1'b1, 1'b1, 1'b0, 7'd3, 40, 2'b10, 7'd3, led_of(0, 1'b1)};
        v[8] = '{1'b1, 1'b1, 1'b1, 7'd0, 40, 2'b10, 7'd0, led_of(0, 1'b1)};
        v[9] = '{1'b0, 1'b1, 1'b0, 7'd0,  5, 2'b00, 7'd0, 8'h00};

        // asynchronous reset with arbitrary inputs, no clock edge needed
        roz = 1'b1; rpm = 7'd5; syg = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset LED", led, 0);
        chk("reset stan", stan, 0);
        chk("reset rpm_akt", akt, 0);
        roz = 1'b0; syg = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            roz = v[i].roz; kier = v[i].kier; rpm = v[i].rpm;
            if (v[i].syg) begin
                syg = 1'b1;
                @(negedge clk);
                syg = 1'b0;
            end
            wait_for(v[i].e_stan, v[i].e_akt, v[i].budget, $sformatf("vec%0d state", i));
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d LED", i), led, v[i].e_led);
        end

        // soft start timing from IDLE
        roz = 1'b1; rpm = 7'd5; kier = 1'b1;
        @(negedge clk);
        chk("start stan", stan, 1);
        @(negedge clk);
        chk("start LED", led, led_of(0, 1'b1));
        for (int k = 1; k <= 3; k++) begin
            int n = 0;
            while (akt != k && n < 40) begin
                @(negedge clk);
                n++;
            end
            ts[k] = cyc;
        end
        chk("ramp step 1-2", ts[2] - ts[1], 8);
        chk("ramp step 2-3", ts[3] - ts[2], 8);
        wait_for(2'b10, 7'd5, 60, "start reach PRACA");

        // sector period at rpm_akt=5: 45 degrees at 5/16 degree per clk
        wait_led(led_of(1, 1'b1), 400, "sector 1", t1);
        wait_led(led_of(2, 1'b1), 400, "sector 2", t2);
        chk_rng("sector period", t2 - t1, 140, 148);
        chk("PRACA held", stan, 2);

        // reverse direction: 2 -> 1 -> 0 -> 7 wrap
        kier = 1'b0;
        wait_led(led_of(1, 1'b0), 250, "rev sector 1", t1);
        wait_led(led_of(0, 1'b0), 250, "rev sector 0", t1);
        wait_led(led_of(7, 1'b0), 250, "rev wrap sector 7", t1);
        chk("rev wrap LED", led, OGON ? 32'h81 : 32'h80);

        // brake, then restart mid-brake keeps rpm_akt
        roz = 1'b0;
        @(negedge clk);
        chk("brake stan", stan, 3);
        begin
            int n = 0;
            while (akt != 7'd4 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("brake ramp down", akt, 4);
        a = akt;
        roz = 1'b1;
        @(negedge clk);
        chk("restart stan", stan, 1);
        chk_rng("restart rpm_akt", int'(akt), int'(a) - 1, int'(a));
        chk("restart LED lit", led != 0, 1);
        wait_for(2'b10, 7'd5, 60, "restart reach PRACA");

        // full brake to IDLE
        roz = 1'b0;
        wait_for(2'b00, 7'd0, 80, "brake to IDLE");
        @(negedge clk);
        chk("IDLE LED", led, 0);

        // asynchronous reset in the middle of ROZRUCH, then rerun
        roz = 1'b1; rpm = 7'd5;
        repeat (12) @(negedge clk);
        chk("mid ROZRUCH stan", stan, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset LED", led, 0);
        chk("mid reset stan", stan, 0);
        chk("mid reset rpm_akt", akt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerun stan", stan, 1);
        wait_for(2'b10, 7'd5, 60, "rerun reach PRACA");
        repeat (2) @(negedge clk);
        chk("rerun LED", led, led_of(0, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
